// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : serial_adder_ctrl (with local cell fa_gl)                      |
// | Description : Bit-serial adder controller. Adds two WIDTH-bit operands LSB |
// |               first, one bit per clock, through a single shared 1-bit      |
// |               full-adder cell. start/done handshake to the requester.      |
// | Config      : SERIAL_ADD_OVF_EN - when defined, adds the ovf output        |
// |               (two's-complement signed overflow of the last add).          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

// Gate-level 1-bit full adder shared by every bit position of the serial add.
module fa_gl (
  input  logic ip1,
  input  logic ip2,
  input  logic ip3,
  output logic carry,
  output logic sum
);

  assign sum   = ip1 ^ ip2 ^ ip3;
  assign carry = (ip1 & ip2) | (ip1 & ip3) | (ip2 & ip3);

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ip1,
  input  logic [WIDTH-1:0] ip2,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;         // operand A, consumed from bit 0
  logic [WIDTH-1:0] b_q, b_d;         // operand B, consumed from bit 0
  logic [WIDTH-1:0] sum_q, sum_d;     // result, filled from the top
  logic             cy_q, cy_d;       // running carry between bit positions
  logic             cout_q, cout_d;   // carry-out of the MSB, held for requester
  logic [CNT_W-1:0] cnt_q, cnt_d;     // bit position currently being added
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             w_fa_sum;
  logic             w_fa_carry;

  fa_gl u_fa (
    .ip1   (a_q[0]),
    .ip2   (b_q[0]),
    .ip3   (cy_q),
    .carry (w_fa_carry),
    .sum   (w_fa_sum)
  );

  // Next-state and datapath update; all registers hold unless the FSM says otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = ip1;
          b_d     = ip2;
          cy_d    = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        sum_d = {w_fa_sum, sum_q[WIDTH-1:1]};
        cy_d  = w_fa_carry;
        if (cnt_q == C_CNT_LAST) begin
          // Counter is left at its terminal value so it never wraps.
          state_d = S_DONE;
          cout_d  = w_fa_carry;
`ifdef SERIAL_ADD_OVF_EN
          // Carry into the MSB differs from carry out of it: signed overflow.
          ovf_d   = w_fa_carry ^ cy_q;
`endif
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they align with it.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

`default_nettype wire
